// File: rtl/fpu_result_buffer.sv
// Result FIFO with valid/ready output and sticky IEEE exception flags behind the FPU rounder.
// Optional trap pulse on masked exceptions: define FPU_RES_TRAP_EN.
module fpu_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_fp,
    input  logic [4:0]       in_ieee,
    input  logic             in_db,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_fp,
    output logic [4:0]       out_ieee,
    output logic             out_db,
    input  logic             flags_clr,
    output logic [4:0]       flags_sticky,
    output logic [CNT_W-1:0] count
`ifdef FPU_RES_TRAP_EN
    ,
    input  logic [4:0]       trap_mask,
    output logic             trap_pulse
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [63:0] fp;
        logic [4:0]  ieee;
        logic        db;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       flags_q, flags_d;
    logic             push, pop;

    // Ready depends only on registered occupancy, so a full buffer with a
    // concurrent pop still refuses the push this cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head     = mem[rd_ptr_q];
    assign out_fp   = out_valid ? head.fp   : '0;
    assign out_ieee = out_valid ? head.ieee : '0;
    assign out_db   = out_valid ? head.db   : 1'b0;

    assign count        = count_q;
    assign flags_sticky = flags_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear takes effect before the new exception bits are merged.
    always_comb begin
        flags_d = flags_clr ? 5'b0 : flags_q;
        if (push) begin
            flags_d = flags_d | in_ieee;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{fp: in_fp, ieee: in_ieee, db: in_db};
        end
    end

`ifdef FPU_RES_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_pulse <= 1'b0;
        end else begin
            trap_pulse <= push && ((in_ieee & trap_mask) != 5'b0);
        end
    end
`endif

endmodule
